// File: rtl/sys_ram_pkg.sv
// Shared constants and FSM state encoding for the sys_ram_dma stream/RAM mover.
package sys_ram_pkg;

  localparam int unsigned SYS_RAM_ADDR_W = 15;
  localparam int unsigned SYS_RAM_DATA_W = 32;
  localparam int unsigned SYS_RAM_LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/sys_ram_dma.sv
// DMA between a valid/ready word stream and a latency-1 on-chip RAM slave.
// Optional XOR checksum of transferred words: define SYS_RAM_DMA_CHECKSUM_EN.
module sys_ram_dma
  import sys_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = SYS_RAM_ADDR_W,
  parameter int unsigned DATA_W = SYS_RAM_DATA_W,
  parameter int unsigned LEN_W  = SYS_RAM_LEN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   base,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  input  logic                abort,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                clken,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata
`ifdef SYS_RAM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   csum
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_nxt;

  // State, current word address and remaining word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign byteenable = '1;

  // Next state plus same-cycle RAM and stream handshake.
  always_comb begin
    w_next     = r_state;
    w_addr_nxt = r_addr;
    w_cnt_nxt  = r_cnt;
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    address    = r_addr;
    chipselect = 1'b0;
    clken      = 1'b0;
    write      = 1'b0;
    writedata  = '0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_addr_nxt = base;
          w_cnt_nxt  = len;
          if (len == '0) begin
            w_next = ST_DONE;
          end else if (dir) begin
            w_next = ST_RD_ISSUE;
          end else begin
            w_next = ST_WR;
          end
        end
      end

      ST_WR: begin
        wr_ready = 1'b1;
        if (abort) begin
          w_next = ST_DONE;
        end else if (wr_valid) begin
          chipselect = 1'b1;
          clken      = 1'b1;
          write      = 1'b1;
          writedata  = wr_data;
          w_addr_nxt = r_addr + ADDR_W'(1);
          w_cnt_nxt  = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            w_next = ST_DONE;
          end
        end
      end

      ST_RD_ISSUE: begin
        if (abort) begin
          w_next = ST_DONE;
        end else begin
          chipselect = 1'b1;
          clken      = 1'b1;
          w_next     = ST_RD_DATA;
        end
      end

      // readdata belongs to r_addr; an accepted beat fetches the next word at once.
      ST_RD_DATA: begin
        rd_valid = 1'b1;
        rd_data  = readdata;
        if (abort) begin
          w_next = ST_DONE;
        end else if (rd_ready) begin
          w_addr_nxt = r_addr + ADDR_W'(1);
          w_cnt_nxt  = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            w_next = ST_DONE;
          end else begin
            chipselect = 1'b1;
            clken      = 1'b1;
            address    = w_addr_nxt;
          end
        end
      end

      ST_DONE: begin
        w_next = ST_IDLE;
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

`ifdef SYS_RAM_DMA_CHECKSUM_EN
  logic              w_load;
  logic              w_wr_beat;
  logic              w_rd_beat;
  logic [DATA_W-1:0] r_csum;

  assign w_load    = (r_state == ST_IDLE) && start;
  assign w_wr_beat = (r_state == ST_WR) && wr_valid && !abort;
  assign w_rd_beat = (r_state == ST_RD_DATA) && rd_ready && !abort;

  // Running XOR of every word that crossed the stream interface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_load) begin
      r_csum <= '0;
    end else if (w_wr_beat) begin
      r_csum <= r_csum ^ wr_data;
    end else if (w_rd_beat) begin
      r_csum <= r_csum ^ readdata;
    end
  end

  assign csum = r_csum;
`endif

endmodule
